// File: rtl/vm_pkg.sv
// Shared vending-machine definitions: coin bus codes used by the encoder, the FSM and their benches.
package vm_pkg;

  typedef logic [1:0] coin_t;

  localparam coin_t COIN_NONE = 2'b00;
  localparam coin_t COIN_5    = 2'b01;
  localparam coin_t COIN_10   = 2'b10;
  localparam coin_t COIN_BAD  = 2'b11;

endpackage

// File: rtl/sync_2ff.sv
// 1-bit two-flop synchronizer for bringing the raw coin sensor into the clk domain.
module sync_2ff (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);

  logic meta;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      meta <= 1'b0;
      q    <= 1'b0;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/coin_encoder.sv
// Coin-chute front end: times sensor pulses, classifies them into a one-cycle coin code,
// and enforces a low-time gap so the downstream FSM never sees merged or bounced coins.
module coin_encoder
  import vm_pkg::*;
#(
  parameter int unsigned CNT_W   = 8,
  parameter int unsigned W5_MIN  = 4,
  parameter int unsigned W5_MAX  = 8,
  parameter int unsigned W10_MIN = 12,
  parameter int unsigned W10_MAX = 16,
  parameter int unsigned TIMEOUT = 32,
  parameter int unsigned GAP     = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       sense,
  input  logic       inhibit,
  output logic [1:0] coin,
  output logic       busy
);

  localparam int unsigned GAP_W = (GAP < 2) ? 1 : $clog2(GAP);

  localparam logic [1:0] ST_IDLE    = 2'd0;
  localparam logic [1:0] ST_MEASURE = 2'd1;
  localparam logic [1:0] ST_STUCK   = 2'd2;
  localparam logic [1:0] ST_GAP     = 2'd3;

  localparam logic [CNT_W-1:0] W5_LO    = CNT_W'(W5_MIN);
  localparam logic [CNT_W-1:0] W5_HI    = CNT_W'(W5_MAX);
  localparam logic [CNT_W-1:0] W10_LO   = CNT_W'(W10_MIN);
  localparam logic [CNT_W-1:0] W10_HI   = CNT_W'(W10_MAX);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);
  localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'(GAP - 1);

  logic             sense_s;
  logic [1:0]       state, state_d;
  logic [CNT_W-1:0] cnt, cnt_d;
  logic [GAP_W-1:0] gap_cnt, gap_cnt_d;
  coin_t            coin_d;
  coin_t            class_c;

  sync_2ff u_sync (
    .clk (clk),
    .rst (rst),
    .d   (sense),
    .q   (sense_s)
  );

  // Width classifier; inhibit forces a reject so the coin is returned.
  always_comb begin
    class_c = COIN_BAD;
    if (!inhibit) begin
      if (cnt >= W5_LO && cnt <= W5_HI)
        class_c = COIN_5;
      else if (cnt >= W10_LO && cnt <= W10_HI)
        class_c = COIN_10;
    end
  end

  always_comb begin
    state_d   = state;
    cnt_d     = cnt;
    gap_cnt_d = gap_cnt;
    coin_d    = COIN_NONE;
    case (state)
      ST_IDLE: begin
        if (sense_s) begin
          state_d = ST_MEASURE;
          cnt_d   = CNT_W'(1);
        end
      end
      ST_MEASURE: begin
        if (sense_s) begin
          if (cnt == CNT_LAST) begin
            coin_d  = COIN_BAD;
            state_d = ST_STUCK;
          end else begin
            cnt_d = cnt + CNT_W'(1);
          end
        end else if (cnt < W5_LO) begin
          state_d = ST_IDLE;
        end else begin
          coin_d    = class_c;
          state_d   = ST_GAP;
          gap_cnt_d = '0;
        end
      end
      ST_STUCK: begin
        if (!sense_s) begin
          state_d   = ST_GAP;
          gap_cnt_d = '0;
        end
      end
      ST_GAP: begin
        // Any high blip restarts the quiet-time requirement and is never measured.
        if (sense_s) begin
          gap_cnt_d = '0;
        end else if (gap_cnt == GAP_LAST) begin
          state_d   = ST_IDLE;
          gap_cnt_d = '0;
        end else begin
          gap_cnt_d = gap_cnt + GAP_W'(1);
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= ST_IDLE;
      cnt     <= '0;
      gap_cnt <= '0;
      coin    <= COIN_NONE;
      busy    <= 1'b0;
    end else begin
      state   <= state_d;
      cnt     <= cnt_d;
      gap_cnt <= gap_cnt_d;
      coin    <= coin_d;
      busy    <= (state != ST_IDLE);
    end
  end

endmodule

// File: tb/tb_coin_encoder.sv
// Directed bench for coin_encoder: table of pulse widths plus hand sequences for noise,
// bounce and mid-pulse reset.
module tb_coin_encoder;
  import vm_pkg::*;

  logic       clk;
  logic       rst;
  logic       sense;
  logic       inhibit;
  logic [1:0] coin;
  logic       busy;

  coin_encoder dut (
    .clk     (clk),
    .rst     (rst),
    .sense   (sense),
    .inhibit (inhibit),
    .coin    (coin),
    .busy    (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    int         width;
    logic       inh;
    logic [1:0] code;
    int         ncodes;
    int         code_idx;
    int         last_busy;
  } vec_t;

  int total;
  int bad;

  // Observation of one window, indexed by sample number j (sample j follows posedge j).
  int         j;
  int         ncodes;
  logic [1:0] last_code;
  int         code_idx;
  int         first_busy;
  int         last_busy;

  task automatic check(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic clear_obs();
    j = 0;
    ncodes = 0;
    last_code = COIN_NONE;
    code_idx = 0;
    first_busy = 0;
    last_busy = 0;
  endtask

  task automatic step(input logic v);
    sense = v;
    @(negedge clk);
    j++;
    if (coin != COIN_NONE) begin
      ncodes++;
      last_code = coin;
      code_idx = j;
    end
    if (busy) begin
      if (first_busy == 0) first_busy = j;
      last_busy = j;
    end
  endtask

  // Hand-computed timing: sense_s trails sense by 2, code lands 3 samples after the drop,
  // jam lands at sample 34, GAP state exits 4 low cycles after it is entered.
  function automatic vec_t mk(input int w, input logic inh, input logic [1:0] code);
    vec_t v;
    v.width = w;
    v.inh = inh;
    v.code = code;
    if (code == COIN_NONE) begin
      v.ncodes = 0;
      v.code_idx = 0;
      v.last_busy = w + 3;
    end else begin
      v.ncodes = 1;
      v.code_idx = (w >= 32) ? 34 : w + 3;
      v.last_busy = w + 7;
    end
    return v;
  endfunction

  vec_t vecs[$];

  initial begin
    total = 0;
    bad = 0;
    rst = 1'b1;
    sense = 1'b0;
    inhibit = 1'b0;
    clear_obs();

    vecs.push_back(mk(6,  1'b0, COIN_5));
    vecs.push_back(mk(14, 1'b0, COIN_10));
    vecs.push_back(mk(10, 1'b0, COIN_BAD));
    vecs.push_back(mk(20, 1'b0, COIN_BAD));
    vecs.push_back(mk(2,  1'b0, COIN_NONE));
    vecs.push_back(mk(3,  1'b0, COIN_NONE));
    vecs.push_back(mk(4,  1'b0, COIN_5));
    vecs.push_back(mk(8,  1'b0, COIN_5));
    vecs.push_back(mk(9,  1'b0, COIN_BAD));
    vecs.push_back(mk(11, 1'b0, COIN_BAD));
    vecs.push_back(mk(12, 1'b0, COIN_10));
    vecs.push_back(mk(16, 1'b0, COIN_10));
    vecs.push_back(mk(17, 1'b0, COIN_BAD));
    vecs.push_back(mk(31, 1'b0, COIN_BAD));
    vecs.push_back(mk(32, 1'b0, COIN_BAD));
    vecs.push_back(mk(40, 1'b0, COIN_BAD));
    vecs.push_back(mk(14, 1'b1, COIN_BAD));
    vecs.push_back(mk(6,  1'b1, COIN_BAD));

    repeat (3) @(negedge clk);
    check("reset_coin", int'(coin), 0);
    check("reset_busy", int'(busy), 0);
    rst = 1'b0;
    repeat (3) @(negedge clk);

    foreach (vecs[i]) begin
      clear_obs();
      inhibit = vecs[i].inh;
      for (int k = 0; k < vecs[i].width; k++) step(1'b1);
      for (int k = 0; k < 20; k++) step(1'b0);
      inhibit = 1'b0;
      check($sformatf("v%0d_w%0d_ncodes", i, vecs[i].width), ncodes, vecs[i].ncodes);
      check($sformatf("v%0d_w%0d_code", i, vecs[i].width), int'(last_code), int'(vecs[i].code));
      check($sformatf("v%0d_w%0d_code_idx", i, vecs[i].width), code_idx, vecs[i].code_idx);
      check($sformatf("v%0d_w%0d_busy_rise", i, vecs[i].width), first_busy, 4);
      check($sformatf("v%0d_w%0d_busy_fall", i, vecs[i].width), last_busy, vecs[i].last_busy);
    end

    // Noise pulse immediately followed by a real 5 Rs coin.
    clear_obs();
    repeat (2) step(1'b1);
    step(1'b0);
    repeat (6) step(1'b1);
    repeat (20) step(1'b0);
    check("noise_then_5_ncodes", ncodes, 1);
    check("noise_then_5_code", int'(last_code), int'(COIN_5));
    check("noise_then_5_idx", code_idx, 12);

    // 5 Rs coin, then a bounce inside the gap that must be swallowed.
    clear_obs();
    repeat (6) step(1'b1);
    repeat (2) step(1'b0);
    repeat (3) step(1'b1);
    repeat (20) step(1'b0);
    check("bounce_ncodes", ncodes, 1);
    check("bounce_code", int'(last_code), int'(COIN_5));
    check("bounce_idx", code_idx, 9);
    check("bounce_busy_fall", last_busy, 17);

    // Reset mid-pulse at cnt=5, then the still-high sensor is measured afresh.
    clear_obs();
    repeat (7) step(1'b1);
    check("pre_reset_busy", int'(busy), 1);
    rst = 1'b1;
    #1;
    check("mid_reset_coin", int'(coin), 0);
    check("mid_reset_busy", int'(busy), 0);
    step(1'b1);
    rst = 1'b0;
    repeat (6) step(1'b1);
    repeat (20) step(1'b0);
    check("post_reset_ncodes", ncodes, 1);
    check("post_reset_code", int'(last_code), int'(COIN_5));
    check("post_reset_idx", code_idx, 17);
    check("post_reset_idle", int'(busy), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/coin_encoder.md
# coin_encoder

Coin-validator front end that drives the 2-bit coin bus consumed by the vending-machine Mealy FSM. It times the high pulse from the coin-chute sensor, classifies it as 5 Rs, 10 Rs or invalid, and emits exactly one single-cycle coin code per coin. It enforces a low-time gap between coins so the FSM never sees merged or bounced codes.

## Interface
Parameters:
- CNT_W, 8: pulse-width counter width.
- W5_MIN, 4: minimum width in cycles for 5 Rs.
- W5_MAX, 8: maximum width for 5 Rs.
- W10_MIN, 12: minimum width for 10 Rs.
- W10_MAX, 16: maximum width for 10 Rs.
- TIMEOUT, 32: width at which the coin is declared jammed. Must be greater than W10_MAX and less than 2^CNT_W.
- GAP, 4: consecutive low cycles required before the next coin is accepted.

Ports:
- clk  in  1  system clock.
- rst  in  1  asynchronous, active-high reset.
- sense  in  1  raw coin sensor, asynchronous to clk.
- inhibit  in  1  synchronous; high while the machine refuses coins.
- coin  out  2  registered coin code: 00 none, 01 5 Rs, 10 10 Rs, 11 wrong/reject. Non-zero for exactly one cycle per coin.
- busy  out  1  registered; high in every state except IDLE.

## Operation
- sense passes through a 2-flop synchronizer to produce sense_s. Every rule below uses sense_s.
- States: IDLE, MEASURE, STUCK, GAP.
- IDLE:
  - sense_s=1: go to MEASURE with cnt=1.
  - Otherwise stay in IDLE.
- MEASURE:
  - sense_s=1 and cnt+1<TIMEOUT: cnt increments.
  - sense_s=1 and cnt+1==TIMEOUT: load coin with 11 and go to STUCK.
  - sense_s=0 with cnt<W5_MIN: treat as noise. Go to IDLE, no code emitted, no gap.
  - sense_s=0 otherwise: classify cnt (inclusive bounds) and load coin. Then go to GAP with gap counter cleared.
    - inhibit=1 at that edge: 11.
    - W5_MIN..W5_MAX: 01.
    - W10_MIN..W10_MAX: 10.
    - Any other width: 11.
- STUCK: hold until sense_s=0, then go to GAP. No further codes are emitted.
- GAP:
  - Gap counter counts consecutive sense_s=0 cycles.
  - Any sense_s=1 clears the gap counter. That pulse is discarded and never measured.
  - On the GAP-th consecutive low cycle, go to IDLE.
- coin returns to 00 the cycle after any non-zero value.
- cnt saturates and never wraps. TIMEOUT < 2^CNT_W guarantees this.
- inhibit affects only classification at pulse end. Timing and gap behaviour are unchanged.

## Timing
- Reset values: coin=00, busy=0, state=IDLE, cnt=0, gap=0, synchronizer flops=0.
- Reset takes effect asynchronously mid-pulse. After release, a sensor still held high is measured as a new pulse from the next sense_s=1.
- Synchronizer latency: 2 cycles from sense to sense_s.
- Width is the number of cycles sense_s=1.
- Normal code: coin is non-zero in the cycle immediately after the first sense_s=0 cycle, for exactly one cycle.
- Jam code: coin=11 in the cycle after cnt reaches TIMEOUT-1 while sense_s is still 1.
- busy rises the cycle after MEASURE is entered. busy falls the cycle after the return to IDLE.
- Minimum spacing between two non-zero codes: 1 + GAP + W5_MIN cycles.

## Structure
- Shared package vm_pkg holds:
  - COIN_NONE=2'b00, COIN_5=2'b01, COIN_10=2'b10, COIN_BAD=2'b11. The vending FSM and its bench use the same constants.
  - State enum localparams stay local to coin_encoder.
- One sub-module: sync_2ff, a 1-bit, 2-flop synchronizer reset to 0 by rst.
- The counter, classifier and FSM stay in coin_encoder. The classifier is combinational on cnt and feeds the coin register.

## Test plan
- Defaults; sense high 6 cycles, then low -> coin=01 for exactly one cycle, 1 cycle after sense_s falls. busy returns to 0 after 4 further low cycles.
- sense high 14 cycles -> coin=10 once. Repeat with width 10 and width 20 -> coin=11 once each.
- sense high 2 cycles -> coin stays 00, busy drops, no gap. An immediate 6-cycle pulse then yields 01.
- sense held high 40 cycles -> coin=11 once at cnt=31, then no further code. After release and 4 low cycles the block is IDLE.
- Width 6 followed after 2 low cycles by a 3-cycle bounce, then 4 low cycles -> exactly one 01. busy stays 1 until the 4th consecutive low cycle after the bounce.
- inhibit=1 with a 14-cycle pulse -> coin=11. rst asserted mid-pulse (cnt=5) -> coin=00 and busy=0 immediately.
